// File: rtl/rr_grant_sequencer.sv
// Eight-way round-robin grant sequencer feeding a 3-to-8 decoder (select + enable).
// Registered grant index/enable/new-pulse with a bounded hold under contention.
module rr_grant_sequencer #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [2:0] gnt_idx,
  output logic       gnt_en,
  output logic       gnt_new
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_n;
  logic [2:0]        ptr, ptr_n;
  logic [2:0]        idx_q, idx_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic              new_q, new_n;

  logic [7:0] cand;
  logic [2:0] win;
  logic [2:0] j;
  logic       any;
  logic       do_grant;

  // While granting, the current holder is masked out so release and forced
  // rotation both pick the next winner from the remaining requesters.
  always_comb begin
    cand = (state == GRANT) ? (req & ~(8'b1 << idx_q)) : req;
    win  = '0;
    any  = 1'b0;
    j    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      j = ptr + 3'(i);
      if (!any && cand[j]) begin
        any = 1'b1;
        win = j;
      end
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    idx_n    = idx_q;
    hold_n   = hold;
    new_n    = 1'b0;
    do_grant = 1'b0;
    case (state)
      IDLE: begin
        if (any) do_grant = 1'b1;
      end
      GRANT: begin
        if (!req[idx_q]) begin
          if (any) do_grant = 1'b1;
          else     state_n  = IDLE;
        end else if (any && (hold == HOLD_MAX)) begin
          do_grant = 1'b1;
        end else if (hold != HOLD_MAX) begin
          hold_n = hold + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (do_grant) begin
      state_n = GRANT;
      idx_n   = win;
      ptr_n   = win + 3'd1;
      hold_n  = HOLD_ONE;
      new_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx_q <= '0;
      hold  <= '0;
      new_q <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      idx_q <= idx_n;
      hold  <= hold_n;
      new_q <= new_n;
    end
  end

  assign gnt_idx = idx_q;
  assign gnt_en  = (state == GRANT);
  assign gnt_new = new_q;

endmodule

// File: doc/rr_grant_sequencer.md
Name: rr_grant_sequencer

Overview:
- Eight-way round-robin arbiter that sits directly upstream of the 3-to-8 decoder.
- Produces a registered 3-bit grant index plus a grant enable. These drive the decoder's select and enable inputs, and the decoder expands them into a one-hot grant bus.
- Bounds how long one requester may hold the grant when others are waiting, so every requester gets service.

Parameters:
- MAX_HOLD, 15: maximum consecutive grant cycles for one requester while any other requester is pending. Legal range 1..(2**HOLD_W - 1).
- HOLD_W, 4: width of the internal hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i high means requester i wants the grant.
- gnt_idx  output  3  index of the current grantee; connects to the decoder select a[2:0].
- gnt_en  output  1  grant valid; connects to the decoder enable.
- gnt_new  output  1  one-cycle pulse in the first cycle of every new grant.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately including mid-grant):
  - gnt_idx=0, gnt_en=0, gnt_new=0.
  - Pointer ptr=0, hold_cnt=0, state=IDLE.
- All outputs are registered. No combinational path from req to any output.
- Pointer: ptr is the highest-priority index for the next arbitration. Priority order is ptr, ptr+1, ..., ptr+7, all mod 8.
  - On every new grant to index k: ptr <= (k+1) mod 8. Wrap from 7 to 0 is required.
- IDLE state:
  - If req==0: remain in IDLE with gnt_en=0; gnt_idx holds its last value.
  - If req!=0 at a clock edge: select the winner k by pointer priority. Next state is GRANT with gnt_idx=k, gnt_en=1, gnt_new=1, hold_cnt=1.
  - Latency: one clock from sampled req to gnt_en high.
- GRANT state, evaluated each edge with g = current gnt_idx:
  - Release: req[g]==0.
    - If other requests are pending, grant the next winner by pointer priority in the same edge (no idle bubble); gnt_new=1, hold_cnt=1.
    - If req==0, go to IDLE; gnt_en=0 on the next cycle.
  - Forced rotation: req[g]==1, hold_cnt==MAX_HOLD, and at least one other req bit is high. Grant the next winner, excluding g; gnt_new=1, hold_cnt=1.
  - Uncontended hold: req[g]==1 and no other requests. Keep the grant; hold_cnt saturates at MAX_HOLD and never wraps.
  - Otherwise: keep the grant; hold_cnt increments.
- gnt_new is high for exactly one cycle per grant. It is low during holds and in IDLE.
- gnt_idx changes only together with gnt_new=1. gnt_en never drops between back-to-back grants.
- Simultaneous release and new request on the same edge: the new winner is chosen from the req vector sampled at that edge, with g excluded.
- MAX_HOLD=1: a contended grant lasts exactly one cycle, giving pure per-cycle round-robin.
- Fairness bound: with all 8 requesters continuously requesting, each is granted once every 8*MAX_HOLD cycles.

Test Plan:
- Reset: drive req=8'hFF, assert rst_n=0 mid-grant -> gnt_en=0, gnt_idx=0 and gnt_new=0 immediately, without waiting for a clock edge. After release, the first grant goes to idx 0.
- Single requester: req=8'b0000_1000 held for 40 cycles -> gnt_idx=3 and gnt_en=1 one cycle after req. gnt_new pulses once, and the grant is held for all 40 cycles. Drop req -> gnt_en=0 on the next cycle.
- Rotation with wrap: ptr=0, req=8'b1000_0001 held, MAX_HOLD=15 -> idx 0 for 15 cycles, then idx 7 for 15 cycles, then idx 0. gnt_new pulses at each switch and gnt_en stays continuously 1.
- Full contention: req=8'hFF, MAX_HOLD=1 -> gnt_idx sequence 0,1,2,...,7,0 on consecutive cycles, with gnt_new high every cycle. The decoder output walks one-hot 00000001 through 10000000.
- Early release, back-to-back: grant on idx 2 with req[5] also pending. Drop req[2] at cycle 4 of the grant -> next cycle gnt_idx=5, gnt_new=1, gnt_en with no bubble. The new grant's hold_cnt restarts, giving a full 15-cycle window.
- Empty-to-request edge: req=0 for 10 cycles (gnt_en=0, gnt_new=0), then req=8'b0100_0000 -> gnt_idx=6 and gnt_en=1 exactly one edge later.
